mem_ring_feeder: RTL and testbench
==================================

// Module: mem_ring_feeder
// PURPOSE
//  Upstream stage of the memory writer: accepts a stream of words (SPI/MIL receive path),
//  buffers them in a small FIFO and issues one writer request per word into a circular
//  region of shared memory [base_addr, base_addr+RING_SIZE). Tracks ring occupancy so a
//  downstream reader can free words; stalls the stream when the FIFO and ring are full.
// PARAMETERS
//  ADDR_W     16  memory address width
//  DATA_W     16  word width
//  RING_SIZE  256 ring length in words; power of two, >=2
//  FIFO_DEPTH 4   staging FIFO depth; power of two, >=2
//  WATERMARK  192 occupancy threshold, used only with MEM_RING_WATERMARK_EN
// PORTS
//  clk         in  1       clock
//  rst         in  1       reset, synchronous, active-high
//  in_data     in  DATA_W  stream word
//  in_valid    in  1       stream word valid
//  in_ready    out 1       FIFO not full; word accepted on in_valid&in_ready at posedge
//  base_addr   in  ADDR_W  ring base; must be static while busy=1
//  wr_request  out 1       request to memory writer
//  wr_addr     out ADDR_W  write address, registered
//  wr_data     out DATA_W  write data, registered
//  wr_done     in  1       one-cycle completion pulse from memory writer
//  free_word   in  1       reader releases one ring word (pulse)
//  used_count  out log2(RING_SIZE)+1  words written and not yet freed
//  ring_full   out 1       used_count == RING_SIZE
//  ring_empty  out 1       used_count == 0
//  busy        out 1       state != IDLE or FIFO non-empty
//  watermark   out 1       only with MEM_RING_WATERMARK_EN
// BEHAVIOUR
//  Reset: state IDLE, wr_ptr=0, used_count=0, FIFO empty, wr_request=0, wr_addr=0,
//   wr_data=0, in_ready=1, ring_empty=1, ring_full=0, watermark=0. Mid-operation reset
//   drops wr_request at the next edge; pending FIFO contents are discarded.
//  FSM: IDLE, REQ.
//   IDLE->REQ when FIFO non-empty && !ring_full: latch wr_data=FIFO head,
//    wr_addr=base_addr+wr_ptr (mod 2^ADDR_W), wr_request=1 from the next cycle.
//   REQ: wr_request held high, addr/data stable until wr_done. On wr_done: pop FIFO,
//    wr_ptr=(wr_ptr+1) mod RING_SIZE, used_count+1. If another word is available and the
//    ring is not full after this write, stay REQ with wr_request kept high and new
//    addr/data latched at the same edge (the writer samples request in its done cycle and
//    rearbitrates); else go IDLE with wr_request=0 at the same edge.
//  Latency: word accepted at edge k (FIFO empty, IDLE) -> wr_request high after edge k+1.
//  wr_done outside REQ is ignored.
//  free_word: used_count-1; ignored when used_count==0. wr_done and free_word in the same
//   cycle: used_count unchanged. Ring full blocks new requests, never drops data.
//  FIFO: in_ready=!fifo_full; simultaneous push and pop on a full FIFO is not permitted
//   (in_ready is low), on an empty FIFO push takes effect, pop never occurs.
//  ring_full/ring_empty/busy derived combinationally from registered state.
// CONFIGURATION
//  MEM_RING_WATERMARK_EN defined: watermark output present, registered,
//   =1 when used_count>=WATERMARK, updated one cycle after used_count changes.
//  Not defined: watermark port and logic absent.
// TESTING
//  Single word 0xA5A5, base 0x0100, after reset -> one request, addr 0x0100, data 0xA5A5,
//   used_count 1 after done.
//  Burst of 4 words, writer done 3 cycles after each request -> wr_request stays high
//   continuously, addrs 0x0100..0x0103 in order.
//  RING_SIZE writes then one more word -> ring_full=1, fifth-from-ring request withheld;
//   one free_word -> request issued at addr base+0 (wrap).
//  FIFO full with ring_full held -> in_ready=0, in_valid words not lost once freed.
//  wr_done and free_word in the same cycle with used_count=5 -> used_count stays 5.
//  rst asserted in REQ -> wr_request 0 next cycle, used_count 0, in_ready 1.

Source files
------------

// File: rtl/mem_ring_feeder.sv
// Purpose : stages a word stream in a small FIFO and issues one memory-writer request per
//           word into the ring [base_addr, base_addr+RING_SIZE), tracking ring occupancy.
// Latency : word accepted into an idle, empty feeder at edge k -> wr_request high after k+1.
// Backpr. : in_ready = !fifo_full; a full ring withholds requests and the FIFO then fills.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_data/in_valid/in_ready  input stream, word taken on in_valid & in_ready
//   base_addr                  ring base, held static while busy
//   wr_request/wr_addr/wr_data registered request to the memory writer
//   wr_done                    one-cycle completion pulse from the writer
//   free_word                  reader releases one ring word
//   used_count                 words written and not yet freed
//   ring_full/ring_empty/busy  status derived from registered state
//   watermark                  used_count >= WATERMARK, registered
//                              (present only when MEM_RING_WATERMARK_EN is defined)
module mem_ring_feeder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RING_SIZE  = 256,
  parameter int FIFO_DEPTH = 4
`ifdef MEM_RING_WATERMARK_EN
  , parameter int WATERMARK = 192
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       wr_request,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_done,
  input  logic                       free_word,
  output logic [$clog2(RING_SIZE):0] used_count,
  output logic                       ring_full,
  output logic                       ring_empty,
  output logic                       busy
`ifdef MEM_RING_WATERMARK_EN
  , output logic                     watermark
`endif
);

  localparam int PTR_W  = $clog2(RING_SIZE);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FPTR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = FPTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic [PTR_W-1:0]    wr_ptr;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0]   fifo_rd;
  logic [FPTR_W-1:0]   fifo_wr;
  logic [FCNT_W-1:0]   fifo_cnt;

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                done_ok;
  logic                dec;
  logic [CNT_W-1:0]    used_next;
  logic [PTR_W-1:0]    wr_ptr_next;
  logic                more;

  always_comb begin
    fifo_full   = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    fifo_empty  = (fifo_cnt == '0);
    push        = in_valid && !fifo_full;
    done_ok     = (state == REQ) && wr_done;
    dec         = free_word && (used_count != '0);
    used_next   = used_count + CNT_W'(done_ok) - CNT_W'(dec);
    wr_ptr_next = wr_ptr + PTR_W'(1);
    // Back-to-back request: a second word already sits behind the head being popped,
    // and the ring still has room once this write and any free are accounted for.
    more        = (fifo_cnt >= FCNT_W'(2)) && (used_next != CNT_W'(RING_SIZE));
  end

  assign in_ready   = !fifo_full;
  assign ring_full  = (used_count == CNT_W'(RING_SIZE));
  assign ring_empty = (used_count == '0);
  assign busy       = (state != IDLE) || !fifo_empty;

  // Storage has no reset; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      used_count <= '0;
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_cnt   <= '0;
      wr_request <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      used_count <= used_next;
      fifo_cnt   <= fifo_cnt + FCNT_W'(push) - FCNT_W'(done_ok);
      if (push)    fifo_wr <= fifo_wr + FPTR_W'(1);
      if (done_ok) fifo_rd <= fifo_rd + FPTR_W'(1);

      case (state)
        IDLE: begin
          if (!fifo_empty && !ring_full) begin
            state      <= REQ;
            wr_request <= 1'b1;
            wr_data    <= fifo_mem[fifo_rd];
            wr_addr    <= base_addr + ADDR_W'(wr_ptr);
          end
        end
        REQ: begin
          if (wr_done) begin
            wr_ptr <= wr_ptr_next;
            if (more) begin
              // Writer re-samples request in its done cycle, so keep it high and
              // present the next word at the same edge.
              wr_data <= fifo_mem[fifo_rd + FPTR_W'(1)];
              wr_addr <= base_addr + ADDR_W'(wr_ptr_next);
            end else begin
              state      <= IDLE;
              wr_request <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          wr_request <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_RING_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (rst) watermark <= 1'b0;
    else     watermark <= (used_count >= CNT_W'(WATERMARK));
  end
`endif

endmodule

// File: tb/tb_mem_ring_feeder.sv
module tb_mem_ring_feeder;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RS = 256;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] base_addr;
  logic          wr_request;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_done;
  logic          free_word;
  logic [8:0]    used_count;
  logic          ring_full;
  logic          ring_empty;
  logic          busy;
`ifdef MEM_RING_WATERMARK_EN
  logic          watermark;
`endif

  mem_ring_feeder #(.ADDR_W(AW), .DATA_W(DW), .RING_SIZE(RS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .base_addr(base_addr), .wr_request(wr_request), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .free_word(free_word), .used_count(used_count),
    .ring_full(ring_full), .ring_empty(ring_empty), .busy(busy)
`ifdef MEM_RING_WATERMARK_EN
    , .watermark(watermark)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic v; logic [15:0] d; logic done; logic free;
    logic req; logic [15:0] addr; logic [15:0] data; logic [8:0] used;
    logic rdy; logic bsy; logic emp;
  } vec_t;
  vec_t vt[12];

  // reference model state for the randomized phase
  logic [15:0] pend[$];
  int          m_used;
  int          m_writes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    wr_done   = 1'b0;
    free_word = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!wr_request && n < budget) begin
      step();
      n++;
    end
    chk(name, {31'd0, wr_request}, 32'd1);
  endtask

  task automatic push_word(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic write_one(input logic [15:0] d);
    push_word(d);
    wait_req("write_one.req", 10);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    base_addr = 16'h0100;
    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    do_reset();
    chk("rst.req",   {31'd0, wr_request}, 32'd0);
    chk("rst.addr",  {16'd0, wr_addr},    32'd0);
    chk("rst.data",  {16'd0, wr_data},    32'd0);
    chk("rst.used",  {23'd0, used_count}, 32'd0);
    chk("rst.rdy",   {31'd0, in_ready},   32'd1);
    chk("rst.empty", {31'd0, ring_empty}, 32'd1);
    chk("rst.full",  {31'd0, ring_full},  32'd0);
    chk("rst.busy",  {31'd0, busy},       32'd0);

    // ---------------- table-driven cycle vectors ----------------
    //          v     d         done  free  req   addr       data       used  rdy   bsy   emp
    vt[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 9'd0, 1'b1, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 16'hA5A5, 9'd0, 1'b1, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 16'hA5A5, 9'd0, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hA5A5, 9'd1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0100, 16'hA5A5, 9'd0, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hA5A5, 9'd0, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0100, 16'hA5A5, 9'd0, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0100, 16'hA5A5, 9'd0, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h0101, 16'h1111, 9'd0, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0102, 16'h2222, 9'd1, 1'b1, 1'b1, 1'b0};
    vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0102, 16'h2222, 9'd1, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0102, 16'h2222, 9'd0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      in_valid  = vt[i].v;
      in_data   = vt[i].d;
      wr_done   = vt[i].done;
      free_word = vt[i].free;
      step();
      chk($sformatf("vec%0d.req", i),  {31'd0, wr_request}, {31'd0, vt[i].req});
      chk($sformatf("vec%0d.addr", i), {16'd0, wr_addr},    {16'd0, vt[i].addr});
      chk($sformatf("vec%0d.data", i), {16'd0, wr_data},    {16'd0, vt[i].data});
      chk($sformatf("vec%0d.used", i), {23'd0, used_count}, {23'd0, vt[i].used});
      chk($sformatf("vec%0d.rdy", i),  {31'd0, in_ready},   {31'd0, vt[i].rdy});
      chk($sformatf("vec%0d.busy", i), {31'd0, busy},       {31'd0, vt[i].bsy});
      chk($sformatf("vec%0d.empty", i),{31'd0, ring_empty}, {31'd0, vt[i].emp});
    end
    idle_inputs();

    // ---------------- burst of 4, writer done 3 cycles after request ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("burst.push_rdy", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 16'hB000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    chk("burst.fifo_full_rdy", {31'd0, in_ready}, 32'd0);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("burst%0d.addr", w), {16'd0, wr_addr}, 32'h0100 + w);
      chk($sformatf("burst%0d.data", w), {16'd0, wr_data}, 32'hB000 + w);
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("burst%0d.hold", w), {31'd0, wr_request}, 32'd1);
        step();
      end
      chk($sformatf("burst%0d.pre_done", w), {31'd0, wr_request}, 32'd1);
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
      chk($sformatf("burst%0d.post_done", w), {31'd0, wr_request}, (w < 3) ? 32'd1 : 32'd0);
    end
    chk("burst.used", {23'd0, used_count}, 32'd4);

    // ---------------- fill the ring, then FIFO backs up behind ring_full ----------------
    do_reset();
    for (int i = 0; i < RS; i++) write_one(16'(i));
    chk("ring.used_full", {23'd0, used_count}, 32'd256);
    chk("ring.full",      {31'd0, ring_full},  32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ring.push_rdy", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 16'hC000 + 16'(i);
      step();
    end
    in_data = 16'hC004;  // held on the bus while the FIFO is full
    for (int i = 0; i < 4; i++) step();
    chk("ring.withheld_req", {31'd0, wr_request}, 32'd0);
    chk("ring.fifo_full_rdy", {31'd0, in_ready},  32'd0);
    free_word = 1'b1;
    step();
    free_word = 1'b0;
    chk("ring.after_free_used", {23'd0, used_count}, 32'd255);
    step();
    chk("ring.wrap_req",  {31'd0, wr_request}, 32'd1);
    chk("ring.wrap_addr", {16'd0, wr_addr},    32'h0100);
    chk("ring.wrap_data", {16'd0, wr_data},    32'hC000);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("ring.refull", {31'd0, ring_full}, 32'd1);
    chk("ring.rdy_after_pop", {31'd0, in_ready}, 32'd1);
    step();  // held word C004 accepted here
    in_valid = 1'b0;
    chk("ring.refill_rdy", {31'd0, in_ready}, 32'd0);
    for (int j = 1; j <= 4; j++) begin
      free_word = 1'b1;
      step();
      free_word = 1'b0;
      wait_req($sformatf("ring.drain%0d.req", j), 10);
      chk($sformatf("ring.drain%0d.addr", j), {16'd0, wr_addr}, 32'h0100 + j);
      chk($sformatf("ring.drain%0d.data", j), {16'd0, wr_data}, 32'hC000 + j);
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
    end
    chk("ring.drain_busy", {31'd0, busy}, 32'd0);

    // ---------------- done and free in the same cycle ----------------
    do_reset();
    for (int i = 0; i < 5; i++) write_one(16'hD000 + 16'(i));
    chk("dnf.used5", {23'd0, used_count}, 32'd5);
    push_word(16'hD005);
    wait_req("dnf.req", 10);
    wr_done   = 1'b1;
    free_word = 1'b1;
    step();
    idle_inputs();
    chk("dnf.used_same", {23'd0, used_count}, 32'd5);

    // ---------------- reset while a request is pending ----------------
    do_reset();
    write_one(16'hE000);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hE001 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    chk("mrst.req_before", {31'd0, wr_request}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.req",  {31'd0, wr_request}, 32'd0);
    chk("mrst.used", {23'd0, used_count}, 32'd0);
    chk("mrst.rdy",  {31'd0, in_ready},   32'd1);
    chk("mrst.busy", {31'd0, busy},       32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("mrst.discarded", {31'd0, wr_request}, 32'd0);

    // ---------------- randomized run against reference model ----------------
    base_addr = 16'hFFC0;  // ring straddles the top of the address space
    do_reset();
    pend.delete();
    m_used   = 0;
    m_writes = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      logic acc;
      logic comp;
      logic dec;
      logic feed;
      logic [15:0] ea;
      feed = (cyc < 3000);
      chk("rnd.used",  {23'd0, used_count}, m_used);
      chk("rnd.rdy",   {31'd0, in_ready},   (pend.size() < FD) ? 32'd1 : 32'd0);
      chk("rnd.full",  {31'd0, ring_full},  (m_used == RS) ? 32'd1 : 32'd0);
      chk("rnd.empty", {31'd0, ring_empty}, (m_used == 0) ? 32'd1 : 32'd0);
      if (wr_request) begin
        chk("rnd.req_room", (m_used < RS && pend.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      end
      if (!feed && pend.size() == 0 && m_used == 0) break;

      in_valid  = feed && ($urandom_range(2) != 0);
      in_data   = 16'($urandom);
      wr_done   = wr_request ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      if (cyc < 1500)      free_word = ($urandom_range(5) == 0);
      else if (feed)       free_word = ($urandom_range(1) == 0);
      else                 free_word = 1'b1;

      acc  = in_valid && (pend.size() < FD);
      comp = wr_request && wr_done;
      dec  = free_word && (m_used > 0);
      if (comp) begin
        ea = base_addr + 16'(m_writes % RS);
        if (pend.size() > 0) begin
          chk("rnd.wr_addr", {16'd0, wr_addr}, {16'd0, ea});
          chk("rnd.wr_data", {16'd0, wr_data}, {16'd0, pend[0]});
          void'(pend.pop_front());
        end
        m_writes++;
      end
      m_used = m_used + (comp ? 1 : 0) - (dec ? 1 : 0);
      if (acc) pend.push_back(in_data);
      step();
    end
    idle_inputs();
    chk("rnd.drained", pend.size(), 32'd0);
    chk("rnd.writes_seen", (m_writes > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
